id_stage_hs: RTL

//  Parametrised decode stage. Accepts instructions from IF over valid/ready, decodes RV32I/RV32E to a class code plus a sign-extended immediate, and reads rs1/rs2.

---
 rtl/id_pkg.sv | 47 ++++
 rtl/id_regfile.sv | 35 +++
 rtl/id_stage_hs.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/id_pkg.sv
// Decode-stage shared types: instruction classes, major opcodes, immediate
// formats and the per-class operand / write-back usage tables.
package id_pkg;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BR, CLS_LD,
    CLS_ST, CLS_ALUI, CLS_ALU, CLS_FENCE, CLS_SYS, CLS_ILL
  } cls_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  // Major opcodes, inst[6:2]
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_JAL   = 5'b11011;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_BR    = 5'b11000;
  localparam logic [4:0] OPC_LD    = 5'b00000;
  localparam logic [4:0] OPC_ST    = 5'b01000;
  localparam logic [4:0] OPC_ALUI  = 5'b00100;
  localparam logic [4:0] OPC_ALU   = 5'b01100;
  localparam logic [4:0] OPC_FENCE = 5'b00011;
  localparam logic [4:0] OPC_SYS   = 5'b11100;

  function automatic logic uses_rs1(cls_t c);
    return c inside {CLS_JALR, CLS_BR, CLS_LD, CLS_ST, CLS_ALUI, CLS_ALU, CLS_SYS};
  endfunction

  function automatic logic uses_rs2(cls_t c);
    return c inside {CLS_BR, CLS_ST, CLS_ALU};
  endfunction

  function automatic logic writes_rd(cls_t c);
    return !(c inside {CLS_ST, CLS_BR, CLS_FENCE, CLS_ILL});
  endfunction

  function automatic imm_fmt_t imm_fmt(cls_t c);
    case (c)
      CLS_ST:             return IMM_S;
      CLS_BR:             return IMM_B;
      CLS_LUI, CLS_AUIPC: return IMM_U;
      CLS_JAL:            return IMM_J;
      default:            return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: NREG x XLEN flops, two combinational read
// ports, one write port; x0 and indices beyond NREG read as zero.
module id_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int ADR_W = 5
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ADR_W-1:0] wa_i,
  input  logic [XLEN-1:0]  wd_i,
  input  logic [ADR_W-1:0] ra1_i,
  output logic [XLEN-1:0]  rd1_o,
  input  logic [ADR_W-1:0] ra2_i,
  output logic [XLEN-1:0]  rd2_o
);

  logic [XLEN-1:0] mem_q [1:NREG-1];

  always_ff @(posedge clk) begin
    for (int i = 1; i < NREG; i++) begin
      if (we_i && wa_i == ADR_W'(i)) mem_q[i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    for (int i = 1; i < NREG; i++) begin
      if (ra1_i == ADR_W'(i)) rd1_o = mem_q[i];
      if (ra2_i == ADR_W'(i)) rd2_o = mem_q[i];
    end
  end

endmodule

// File: rtl/id_stage_hs.sv
// Decode stage: RV32I/E decode, RAW busy scoreboard, 2-entry output queue; head valid the cycle after accept.
// in_ready drops when the queue is full, an operand is busy, or on flush/rst; ID_WB_BYPASS_EN forwards wb_data at accept.
module id_stage_hs
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int ADR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_in,
  input  logic [XLEN-3:0]  pc_in,
  input  logic             wb_en,
  input  logic [ADR_W-1:0] wb_adr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       cls_out,
  output logic [3:0]       alu_op_out,
  output logic [XLEN-1:0]  imm_out,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [ADR_W-1:0] rd_adr,
  output logic             wbk_rd_reg,
  output logic [XLEN-3:0]  pc_out,
  output logic [31:0]      inst_out,
  output logic             illegal_out
);

  typedef struct packed {
    cls_t             cls;
    logic [3:0]       alu_op;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [ADR_W-1:0] rd;
    logic             wbk;
    logic [XLEN-3:0]  pc;
    logic [31:0]      inst;
    logic             ill;
  } entry_t;

  logic [4:0]       opc;
  logic [2:0]       funct3;
  logic [ADR_W-1:0] rs1_a, rs2_a, rd_a;
  cls_t             cls_raw, cls_dec;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  rf_rd1, rf_rd2;
  logic             byp1, byp2, hazard, accept, pop;
  entry_t           new_ent, head_q, head_d, tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [(1<<ADR_W)-1:0] busy_q, busy_d;

  assign opc    = inst_in[6:2];
  assign funct3 = inst_in[14:12];
  assign rs1_a  = inst_in[19:15];
  assign rs2_a  = inst_in[24:20];
  assign rd_a   = inst_in[11:7];

  always_comb begin
    cls_raw = CLS_ILL;
    case (opc)
      OPC_LUI:   cls_raw = CLS_LUI;
      OPC_AUIPC: cls_raw = CLS_AUIPC;
      OPC_JAL:   cls_raw = CLS_JAL;
      OPC_JALR:  if (funct3 == 3'b000) cls_raw = CLS_JALR;
      OPC_BR:    cls_raw = CLS_BR;
      OPC_LD:    cls_raw = CLS_LD;
      OPC_ST:    cls_raw = CLS_ST;
      OPC_ALUI:  cls_raw = CLS_ALUI;
      OPC_ALU:   if ({inst_in[31], inst_in[29:25]} == 6'b0) cls_raw = CLS_ALU;
      OPC_FENCE: cls_raw = CLS_FENCE;
      OPC_SYS:   cls_raw = CLS_SYS;
      default:   cls_raw = CLS_ILL;
    endcase
    if (inst_in[1:0] != 2'b11) cls_raw = CLS_ILL;
  end

  // RV32E: any referenced register above x15 makes the op illegal
  always_comb begin
    cls_dec = cls_raw;
    if (NREG == 16 && ((uses_rs1(cls_raw) && rs1_a[4]) ||
                       (uses_rs2(cls_raw) && rs2_a[4]) ||
                       (writes_rd(cls_raw) && rd_a[4])))
      cls_dec = CLS_ILL;
  end

  always_comb begin
    case (imm_fmt(cls_dec))
      IMM_S:   imm32 = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
      IMM_B:   imm32 = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
      IMM_U:   imm32 = {inst_in[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};
      default: imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
    endcase
    if (cls_dec == CLS_ALU || cls_dec == CLS_ILL) imm32 = '0;
  end

  id_regfile #(.XLEN(XLEN), .NREG(NREG), .ADR_W(ADR_W)) u_rf (
    .clk   (clk),
    .we_i  (wb_en),
    .wa_i  (wb_adr),
    .wd_i  (wb_data),
    .ra1_i (rs1_a),
    .rd1_o (rf_rd1),
    .ra2_i (rs2_a),
    .rd2_o (rf_rd2)
  );

`ifdef ID_WB_BYPASS_EN
  assign byp1 = wb_en && (wb_adr == rs1_a) && (rs1_a != '0);
  assign byp2 = wb_en && (wb_adr == rs2_a) && (rs2_a != '0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign hazard   = (uses_rs1(cls_dec) && busy_q[rs1_a] && !byp1) ||
                    (uses_rs2(cls_dec) && busy_q[rs2_a] && !byp2);
  assign in_ready = !rst && !flush && (count_q < 2'd2) && !hazard;
  assign accept   = in_valid && in_ready;
  assign out_valid = (count_q != 2'd0);
  assign pop      = out_valid && out_ready;

  always_comb begin
    new_ent        = '0;
    new_ent.cls    = cls_dec;
    new_ent.alu_op = {inst_in[30], funct3};
    new_ent.imm    = XLEN'($signed(imm32));
    new_ent.rs1    = byp1 ? wb_data : rf_rd1;
    new_ent.rs2    = byp2 ? wb_data : rf_rd2;
    new_ent.rd     = rd_a;
    new_ent.wbk    = writes_rd(cls_dec);
    new_ent.pc     = pc_in;
    new_ent.inst   = inst_in;
    new_ent.ill    = (cls_dec == CLS_ILL);
  end

  // Head is always slot 0; the tail shifts forward on pop
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    busy_d  = busy_q;
    if (flush) begin
      count_d = 2'd0;
      if (count_q != 2'd0 && head_q.wbk) busy_d[head_q.rd] = 1'b0;
      if (count_q == 2'd2 && tail_q.wbk) busy_d[tail_q.rd] = 1'b0;
    end else begin
      if (accept) begin
        if (count_q == 2'd0 || (pop && count_q == 2'd1)) begin
          head_d = new_ent;
        end else if (pop) begin
          head_d = tail_q;
          tail_d = new_ent;
        end else begin
          tail_d = new_ent;
        end
      end else if (pop) begin
        head_d = tail_q;
      end
      count_d = count_q + 2'(accept) - 2'(pop);
    end
    if (wb_en) busy_d[wb_adr] = 1'b0;
    if (accept && new_ent.wbk && new_ent.rd != '0) busy_d[new_ent.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign cls_out     = head_q.cls;
  assign alu_op_out  = head_q.alu_op;
  assign imm_out     = head_q.imm;
  assign rs1_data    = head_q.rs1;
  assign rs2_data    = head_q.rs2;
  assign rd_adr      = head_q.rd;
  assign wbk_rd_reg  = head_q.wbk;
  assign pc_out      = head_q.pc;
  assign inst_out    = head_q.inst;
  assign illegal_out = head_q.ill;

endmodule
